// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // Bit counter width; needs to count 0..width-1.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle between a serial_add user (master) and the adder (slave).
interface serial_add_if
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  ready, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output ready, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_full_add.sv
// One-bit full adder used as the serial bit cell.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    // Sum and majority carry.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end
endmodule

// File: rtl/serial_add.sv
// Bit-serial ripple adder: one full-adder cell, LSB first, WIDTH clocks per add.
// Optional macro SERIAL_ADD_OVF_EN enables the signed-overflow flag; otherwise ovf is 0.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_add_if.slave bus
);
    localparam int unsigned    CntW    = cnt_w(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic             accept, last;

    full_add u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (c_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    assign accept = (state_q == StIdle) && bus.start;
    assign last   = (state_q == StShift) && (cnt_q == LastCnt);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: WIDTH edges in SHIFT, then a single DONE cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StShift;
            StShift: if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        bus.ready = (state_q == StIdle);
        bus.done  = (state_q == StDone);
        bus.sum   = sum_q;
        bus.cout  = cout_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q <= '0;
            b_sr_q <= '0;
            sum_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            a_sr_q <= a_sr_d;
            b_sr_q <= b_sr_d;
            sum_q  <= sum_d;
            c_q    <= c_d;
            cout_q <= cout_d;
            cnt_q  <= cnt_d;
        end
    end

    // Datapath next-state: load on accept, shift one bit per SHIFT edge.
    always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        sum_d  = sum_q;
        c_d    = c_q;
        cout_d = cout_q;
        cnt_d  = cnt_q;
        if (accept) begin
            a_sr_d = bus.a;
            b_sr_d = bus.b;
            c_d    = bus.cin;
            cnt_d  = '0;
            sum_d  = '0;
            cout_d = 1'b0;
        end else if (state_q == StShift) begin
            sum_d  = {fa_s, sum_q[WIDTH-1:1]};
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            c_d    = fa_co;
            cnt_d  = cnt_q + 1'b1;
            if (last) cout_d = fa_co;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow register: on the last edge c_q is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Overflow next-state: cleared on accept, set from carry-in/out of the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (last) begin
            ovf_d = c_q ^ fa_co;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add.sv
module tb_serial_add;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_add_if #(.WIDTH(W)) bus ();

    serial_add #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic fa_a, fa_b, fa_c, fa_s, fa_co;

    full_add u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (fa_c),
        .sum  (fa_s),
        .cout (fa_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition; ovf from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0] full;
        logic       o;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`ifdef SERIAL_ADD_OVF_EN
        o = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`else
        o = 1'b0;
`endif
        return {o, full};
    endfunction

    // Drives one operation from IDLE; collects latency and result (no checking).
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                          output int lat, output logic [W-1:0] s, output logic c,
                          output logic o, output logic rdy_after);
        bus.a     = ia;
        bus.b     = ib;
        bus.cin   = icin;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= int'(W) + 4; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        s = bus.sum;
        c = bus.cout;
        o = bus.ovf;
        @(posedge clk); #1;
        rdy_after = bus.ready;
    endtask

    task automatic test_reset();
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum got %h exp 00", bus.sum); end
        checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", bus.cout); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.ovf); end
    endtask

    task automatic test_full_add();
        int n;
        for (int i = 0; i < 8; i++) begin
            fa_a = i[2];
            fa_b = i[1];
            fa_c = i[0];
            #1;
            n = int'(fa_a) + int'(fa_b) + int'(fa_c);
            checks++;
            if (fa_s !== n[0]) begin
                errors++; $display("FAIL fa_sum in=%0d got %b exp %b", i, fa_s, n[0]);
            end
            checks++;
            if (fa_co !== (n >= 2)) begin
                errors++; $display("FAIL fa_cout in=%0d got %b exp %b", i, fa_co, n >= 2);
            end
        end
    endtask

    task automatic test_ops(input int count, input bit directed);
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vc [6];
        logic [W-1:0] ta, tb, s;
        logic         tc, c, o, rdy;
        logic [W+1:0] exp;
        int           lat;
        va = '{8'h0F, 8'hFF, 8'h7F, 8'h00, 8'hAA, 8'h80};
        vb = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h55, 8'h80};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < count; k++) begin
            if (directed) begin
                ta = va[k]; tb = vb[k]; tc = vc[k];
            end else begin
                ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
            end
            exp = model(ta, tb, tc);
            run_op(ta, tb, tc, lat, s, c, o, rdy);
            checks++;
            if (lat !== int'(W)) begin
                errors++; $display("FAIL op_latency %h+%h+%b got %0d exp %0d", ta, tb, tc, lat, W);
            end
            checks++;
            if (s !== exp[W-1:0]) begin
                errors++; $display("FAIL op_sum %h+%h+%b got %h exp %h", ta, tb, tc, s, exp[W-1:0]);
            end
            checks++;
            if (c !== exp[W]) begin
                errors++; $display("FAIL op_cout %h+%h+%b got %b exp %b", ta, tb, tc, c, exp[W]);
            end
            checks++;
            if (o !== exp[W+1]) begin
                errors++; $display("FAIL op_ovf %h+%h+%b got %b exp %b", ta, tb, tc, o, exp[W+1]);
            end
            checks++;
            if (rdy !== 1'b1) begin
                errors++; $display("FAIL op_ready_after got %b exp 1", rdy);
            end
        end
    endtask

    task automatic test_ignored_start();
        int           dones;
        int           lat;
        logic [W-1:0] s;
        logic         c;
        dones = 0;
        lat   = -1;
        s     = '0;
        c     = 1'b0;
        bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= int'(W) + 6; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = i; s = bus.sum; c = bus.cout;
                end
                bus.start = 1'b1;
                bus.a = 8'hFF; bus.b = 8'hFF;
            end
            if (i == 3) begin
                bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
            end
        end
        checks++; if (lat !== int'(W)) begin errors++; $display("FAIL ign_latency got %0d exp %0d", lat, W); end
        checks++; if (s !== 8'h30) begin errors++; $display("FAIL ign_sum got %h exp 30", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL ign_cout got %b exp 0", c); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", dones); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL ign_ready got %b exp 1", bus.ready); end
    endtask

    task automatic test_reset_abort();
        int           lat;
        logic [W-1:0] s;
        logic         c, o, rdy;
        bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", bus.done); end
        checks++; if (bus.sum !== '0) begin errors++; $display("FAIL abort_sum got %h exp 00", bus.sum); end
        checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL abort_cout got %b exp 0", bus.cout); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h03, 8'h04, 1'b0, lat, s, c, o, rdy);
        checks++; if (lat !== int'(W)) begin errors++; $display("FAIL post_abort_latency got %0d exp %0d", lat, W); end
        checks++; if (s !== 8'h07) begin errors++; $display("FAIL post_abort_sum got %h exp 07", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL post_abort_cout got %b exp 0", c); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL post_abort_ready got %b exp 1", rdy); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        #12;
        test_reset();
        test_full_add();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_ops(6, 1'b1);
        test_ignored_start();
        test_reset_abort();
        test_ops(40, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
Bit-serial ripple adder, the additive counterpart to the team's full subtractor. It takes two WIDTH-bit operands plus carry-in under a start/ready handshake. It computes one bit per clock, LSB first, through a single full-adder cell and a registered carry. It is used in area-constrained datapaths where a parallel adder is too large; it returns sum, carry-out and a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while ready=1
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse; sum/cout valid
sum  output  WIDTH  result; held until next accepted start
cout  output  1  final carry-out; held like sum
ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, ready=1, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry register and bit counter are all 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1, capture a, b, cin (carry reg <= cin) and clear the counter (cnt <= 0).
  - On that same edge, clear sum, cout and ovf, then go to SHIFT.
  - start=0 stays in IDLE; all outputs hold.
- SHIFT (ready=0):
  - Each edge: full-adder cell computes s = a_sr[0]^b_sr[0]^c and co = majority(a_sr[0], b_sr[0], c).
  - s shifts into the sum register MSB, which shifts right; a_sr and b_sr shift right; c <= co; cnt++.
  - On the edge where cnt == WIDTH-1, the last bit is processed, cout <= co, and the state goes to DONE.
  - Exactly WIDTH edges are spent in SHIFT.
- DONE: done=1 for exactly this one cycle, ready=0. The next edge goes to IDLE unconditionally.
- Latency: the accepted start edge is E0. done is high in the cycle after edge E(WIDTH), and ready returns after E(WIDTH+1). Throughput is one operation per WIDTH+2 cycles.
- start while ready=0 (SHIFT or DONE) is ignored, with no queueing; a and b may change freely after acceptance.
- sum/cout are intermediate (partially shifted) during SHIFT. They are guaranteed valid from the done cycle until the next accepted start.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no truncation beyond that.
- Counter width is $clog2(WIDTH).
- Reset asserted mid-operation aborts immediately and asynchronously to the reset values. No done pulse is issued for the aborted operation.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined: a register captures the carry into the MSB (the c value on the final SHIFT edge). On that edge, ovf <= c_in_msb ^ co, i.e. two's-complement overflow. ovf is valid and held with sum/cout.
- Undefined: ovf is tied to 0 and the extra register is absent. The port list is unchanged.

Decomposition:
- Shared package serial_add_pkg holds:
  - state enum typedef (IDLE, SHIFT, DONE);
  - localparam DEFAULT_WIDTH = 8;
  - a function cnt_w(width) returning the counter width.
- Sub-module full_add (a, b, cin -> sum, cout) is purely combinational and instantiated once as the bit cell.
- It is the additive dual of full_sub, and the bench can unit-check it exhaustively over 8 input combinations.

Test Plan:
- WIDTH=8: a=0x0F, b=0x01, cin=0, start pulse -> done exactly 8 edges after the accept edge; sum=0x10, cout=0, ovf=0; ready back 1 cycle later.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; ovf=0 with the macro defined.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0; ovf=1 with SERIAL_ADD_OVF_EN, ovf=0 without.
- a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0. Then a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1.
- Accept a=0x10, b=0x20; pulse start again with a=0xFF, b=0xFF at SHIFT cycle 3 and in the DONE cycle -> both ignored; result sum=0x30, cout=0; exactly one done pulse.
- Drop rst_n mid-SHIFT (cycle 4) -> same cycle: ready=1, done=0, sum=0, cout=0. After release, a=0x03 + b=0x04 -> sum=0x07 with normal latency.
